// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - fetch/data arbiter for the single unified memory port
// One transaction outstanding; data wins unless fetch has waited STARVE_MAX data grants.
module mem_port_arbiter #(
   parameter int AW         = 32,
   parameter int DW         = 32,
   parameter int STARVE_MAX = 4
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            i_req,
   input  logic [AW-1:0]   i_addr,
   input  logic            i_flush,
   output logic            i_ack,
   output logic [DW-1:0]   i_rdata,
   input  logic            d_req,
   input  logic            d_we,
   input  logic [AW-1:0]   d_addr,
   input  logic [DW-1:0]   d_wdata,
   input  logic [DW/8-1:0] d_be,
   output logic            d_ack,
   output logic [DW-1:0]   d_rdata,
   output logic            m_req,
   output logic            m_we,
   output logic [AW-1:0]   m_addr,
   output logic [DW-1:0]   m_wdata,
   output logic [DW/8-1:0] m_be,
   input  logic            m_gnt,
   input  logic            m_rvalid,
   input  logic [DW-1:0]   m_rdata,
   output logic            stall_f,
   output logic            stall_m
);

   localparam int CW = $clog2(STARVE_MAX + 1);
   localparam logic [CW-1:0] STARVE_LIM = CW'(STARVE_MAX);

   typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT} state_t;

   state_t        r_state;
   logic          r_own_i;
   logic          r_own_d;
   logic          r_drop;
   logic [CW-1:0] r_starve;

   logic w_i_ok;
   logic w_force_i;
   logic w_d_win;
   logic w_i_win;
   logic w_rsp;

   assign w_i_ok    = i_req & ~i_flush;
   assign w_force_i = w_i_ok & (r_starve == STARVE_LIM);
   assign w_d_win   = d_req & ~w_force_i;
   assign w_i_win   = w_i_ok & ~w_d_win;
   assign w_rsp     = (r_state == S_WAIT) & m_rvalid;

   // A flush in the response cycle itself must also kill the fetch ack.
   assign i_ack   = w_rsp & r_own_i & ~r_drop & ~i_flush;
   assign d_ack   = w_rsp & r_own_d;
   assign i_rdata = m_rdata;
   assign d_rdata = m_rdata;
   assign stall_f = i_req & ~i_ack;
   assign stall_m = d_req & ~d_ack;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state  <= S_IDLE;
         r_own_i  <= 1'b0;
         r_own_d  <= 1'b0;
         r_drop   <= 1'b0;
         r_starve <= '0;
         m_req    <= 1'b0;
         m_we     <= 1'b0;
         m_addr   <= '0;
         m_wdata  <= '0;
         m_be     <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_d_win) begin
                  r_state <= S_REQ;
                  r_own_d <= 1'b1;
                  m_req   <= 1'b1;
                  m_we    <= d_we;
                  m_addr  <= d_addr;
                  m_wdata <= d_wdata;
                  m_be    <= d_be;
                  if (!i_req)
                     r_starve <= '0;
                  else if (r_starve != STARVE_LIM)
                     r_starve <= r_starve + CW'(1);
               end else if (w_i_win) begin
                  r_state  <= S_REQ;
                  r_own_i  <= 1'b1;
                  m_req    <= 1'b1;
                  m_we     <= 1'b0;
                  m_addr   <= i_addr;
                  m_wdata  <= '0;
                  m_be     <= '1;
                  r_starve <= '0;
               end
            end
            S_REQ: begin
               if (r_own_i && i_flush)
                  r_drop <= 1'b1;
               if (m_gnt) begin
                  m_req   <= 1'b0;
                  r_state <= S_WAIT;
               end
            end
            S_WAIT: begin
               if (r_own_i && i_flush)
                  r_drop <= 1'b1;
               if (m_rvalid) begin
                  r_state <= S_IDLE;
                  r_own_i <= 1'b0;
                  r_own_d <= 1'b0;
                  r_drop  <= 1'b0;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - directed-vector bench for mem_port_arbiter
module tb_mem_port_arbiter;

   logic        clk = 1'b0;
   logic        reset;
   logic        i_req, i_flush, i_ack;
   logic [31:0] i_addr, i_rdata;
   logic        d_req, d_we, d_ack;
   logic [31:0] d_addr, d_wdata, d_rdata;
   logic [3:0]  d_be;
   logic        m_req, m_we, m_gnt, m_rvalid;
   logic [31:0] m_addr, m_wdata, m_rdata;
   logic [3:0]  m_be;
   logic        stall_f, stall_m;

   int n_vec  = 0;
   int n_miss = 0;
   int n_dack;
   logic [31:0] exp_seq [10];

   mem_port_arbiter #(.AW(32), .DW(32), .STARVE_MAX(4)) dut (
      .clk(clk), .reset(reset),
      .i_req(i_req), .i_addr(i_addr), .i_flush(i_flush), .i_ack(i_ack), .i_rdata(i_rdata),
      .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_be(d_be),
      .d_ack(d_ack), .d_rdata(d_rdata),
      .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata), .m_be(m_be),
      .m_gnt(m_gnt), .m_rvalid(m_rvalid), .m_rdata(m_rdata),
      .stall_f(stall_f), .stall_m(stall_m)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_miss++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic nxt();
      @(posedge clk);
      #1;
   endtask

   task automatic smp();
      @(negedge clk);
   endtask

   initial begin
      reset = 1'b1;
      i_req = 0; i_flush = 0; i_addr = 0;
      d_req = 0; d_we = 0; d_addr = 0; d_wdata = 0; d_be = 0;
      m_gnt = 0; m_rvalid = 0; m_rdata = 0;
      #2;
      chk("rst_m_req", m_req, 0);
      chk("rst_m_we", m_we, 0);
      chk("rst_m_addr", m_addr, 0);
      chk("rst_m_be", m_be, 0);
      chk("rst_i_ack", i_ack, 0);
      chk("rst_d_ack", d_ack, 0);
      nxt(); nxt();
      reset = 1'b0;

      // fetch only, zero-wait memory
      nxt(); i_req = 1; i_addr = 32'h100; m_gnt = 1; smp();
      chk("t1_c0_stall_f", stall_f, 1);
      chk("t1_c0_m_req", m_req, 0);
      nxt(); smp();
      chk("t1_c1_m_req", m_req, 1);
      chk("t1_c1_m_addr", m_addr, 32'h100);
      chk("t1_c1_m_we", m_we, 0);
      chk("t1_c1_m_be", m_be, 4'hF);
      chk("t1_c1_stall_f", stall_f, 1);
      nxt(); m_rvalid = 1; m_rdata = 32'h00500093; smp();
      chk("t1_c2_i_ack", i_ack, 1);
      chk("t1_c2_i_rdata", i_rdata, 32'h00500093);
      chk("t1_c2_stall_f", stall_f, 0);
      chk("t1_c2_m_req", m_req, 0);
      nxt(); i_req = 0; m_rvalid = 0; smp();
      chk("t1_c3_i_ack", i_ack, 0);

      // simultaneous requests: data store first, then fetch
      nxt(); i_req = 1; i_addr = 32'h104; d_req = 1; d_we = 1; d_addr = 32'h2000;
      d_wdata = 32'hDEADBEEF; d_be = 4'hF; smp();
      nxt(); smp();
      chk("t2_m_req", m_req, 1);
      chk("t2_m_we", m_we, 1);
      chk("t2_m_addr", m_addr, 32'h2000);
      chk("t2_m_wdata", m_wdata, 32'hDEADBEEF);
      chk("t2_m_be", m_be, 4'hF);
      chk("t2_stall_f", stall_f, 1);
      chk("t2_stall_m", stall_m, 1);
      nxt(); m_rvalid = 1; smp();
      chk("t2_d_ack", d_ack, 1);
      chk("t2_i_ack_quiet", i_ack, 0);
      chk("t2_stall_m_rel", stall_m, 0);
      nxt(); d_req = 0; d_we = 0; m_rvalid = 0; smp();
      chk("t2_idle_m_req", m_req, 0);
      nxt(); smp();
      chk("t2_f_m_req", m_req, 1);
      chk("t2_f_m_addr", m_addr, 32'h104);
      chk("t2_f_m_we", m_we, 0);
      nxt(); m_rvalid = 1; smp();
      chk("t2_f_i_ack", i_ack, 1);
      nxt(); i_req = 0; m_rvalid = 0; smp();

      // starvation: D,D,D,D,I,D,D,D,D,I
      for (int k = 0; k < 10; k++)
         exp_seq[k] = (k == 4 || k == 9) ? 32'h300 : 32'h4000;
      nxt(); i_req = 1; i_addr = 32'h300; d_req = 1; d_we = 0; d_addr = 32'h4000;
      m_gnt = 1; m_rvalid = 1; smp();
      for (int k = 0; k < 10; k++) begin
         nxt(); smp();
         chk($sformatf("t3_g%0d_m_req", k), m_req, 1);
         chk($sformatf("t3_g%0d_m_addr", k), m_addr, exp_seq[k]);
         nxt(); smp();
         chk($sformatf("t3_g%0d_i_ack", k), i_ack, exp_seq[k] == 32'h300);
         chk($sformatf("t3_g%0d_d_ack", k), d_ack, exp_seq[k] == 32'h4000);
         nxt();
         if (k == 9) begin
            i_req = 0; d_req = 0; m_rvalid = 0;
         end
         smp();
      end

      // delayed grant and response
      nxt(); m_gnt = 0; m_rvalid = 0; d_req = 1; d_we = 0; d_addr = 32'h5000; n_dack = 0; smp();
      for (int c = 1; c <= 10; c++) begin
         nxt();
         m_gnt = (c == 4);
         m_rvalid = (c == 9);
         if (c == 9) m_rdata = 32'hCAFEF00D;
         if (c == 10) d_req = 0;
         smp();
         n_dack += int'(d_ack);
         chk($sformatf("t4_c%0d_m_req", c), m_req, c <= 4);
         if (c <= 4) chk($sformatf("t4_c%0d_m_addr", c), m_addr, 32'h5000);
         chk($sformatf("t4_c%0d_stall_m", c), stall_m, c < 9);
         if (c == 9) chk("t4_d_rdata", d_rdata, 32'hCAFEF00D);
      end
      chk("t4_n_dack", n_dack, 1);

      // flush during WAIT, pending data request served next
      nxt(); m_rvalid = 0; m_gnt = 1; i_req = 1; i_addr = 32'h600; smp();
      nxt(); smp();
      chk("t5_m_addr", m_addr, 32'h600);
      nxt(); i_flush = 1; d_req = 1; d_we = 0; d_addr = 32'h7000; smp();
      chk("t5_wait_i_ack", i_ack, 0);
      nxt(); i_flush = 0; i_req = 0; m_rvalid = 1; smp();
      chk("t5_drop_i_ack", i_ack, 0);
      chk("t5_drop_d_ack", d_ack, 0);
      nxt(); m_rvalid = 0; smp();
      chk("t5_idle_m_req", m_req, 0);
      nxt(); smp();
      chk("t5_d_m_req", m_req, 1);
      chk("t5_d_m_addr", m_addr, 32'h7000);
      nxt(); m_rvalid = 1; smp();
      chk("t5_d_ack", d_ack, 1);
      chk("t5_i_ack", i_ack, 0);
      nxt(); d_req = 0; m_rvalid = 0; smp();

      // flush in IDLE blocks grant; flush with m_rvalid suppresses ack
      nxt(); i_req = 1; i_flush = 1; i_addr = 32'h900; smp();
      nxt(); i_flush = 0; smp();
      chk("t6_idle_flush_block", m_req, 0);
      nxt(); smp();
      chk("t6_m_req", m_req, 1);
      chk("t6_m_addr", m_addr, 32'h900);
      nxt(); m_rvalid = 1; i_flush = 1; smp();
      chk("t6_same_cycle_flush", i_ack, 0);
      nxt(); i_req = 0; i_flush = 0; m_rvalid = 0; smp();
      chk("t6_back_idle", m_req, 0);

      // reset during WAIT
      nxt(); d_req = 1; d_we = 1; d_addr = 32'h8000; d_wdata = 32'h12345678; d_be = 4'h3; smp();
      nxt(); smp();
      chk("t7_m_be", m_be, 4'h3);
      chk("t7_m_we", m_we, 1);
      nxt(); smp();
      chk("t7_wait_m_req", m_req, 0);
      #2; reset = 1; d_req = 0; m_rvalid = 1; #1;
      chk("t7_rst_m_we", m_we, 0);
      chk("t7_rst_m_addr", m_addr, 0);
      chk("t7_rst_m_wdata", m_wdata, 0);
      chk("t7_rst_m_be", m_be, 0);
      chk("t7_rst_d_ack", d_ack, 0);
      chk("t7_rst_i_ack", i_ack, 0);
      nxt(); reset = 0; smp();
      chk("t7_late_d_ack", d_ack, 0);
      chk("t7_late_i_ack", i_ack, 0);
      nxt(); m_rvalid = 0; smp();
      chk("t7_after_m_req", m_req, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
Shares the single unified memory port between the instruction-fetch stage (read-only) and the memory stage (load/store) of the 5-stage RISC-V pipeline. It arbitrates, sequences one outstanding transaction at a time over a valid/grant/response memory interface, and returns responses to the owner. It generates stall_f/stall_m for the hazard logic and discards fetch responses killed by a taken branch (i_flush = PcSrcE).

Parameters:
AW, 32, address width
DW, 32, data width
STARVE_MAX, 4, max consecutive data grants while fetch waits before fetch is forced in (>=1)

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-high reset
i_req  in  1  fetch request, level, held until i_ack or i_flush
i_addr  in  AW  fetch address
i_flush  in  1  kill in-flight/pending fetch (taken branch)
i_ack  out  1  fetch response valid, 1-cycle pulse
i_rdata  out  DW  fetch data, valid with i_ack
d_req  in  1  data request, level, held until d_ack
d_we  in  1  1=store, 0=load
d_addr  in  AW  data address
d_wdata  in  DW  store data
d_be  in  DW/8  store byte enables
d_ack  out  1  data response valid, 1-cycle pulse
d_rdata  out  DW  load data, valid with d_ack
m_req  out  1  memory request valid
m_we  out  1  memory write
m_addr  out  AW  memory address
m_wdata  out  DW  memory write data
m_be  out  DW/8  memory byte enables
m_gnt  in  1  memory accepts request this cycle
m_rvalid  in  1  memory response (read data or write done)
m_rdata  in  DW  memory read data
stall_f  out  1  i_req & ~i_ack
stall_m  out  1  d_req & ~d_ack

Behaviour:
- Reset (async, active-high): state=IDLE, owner=none, drop=0, starve_cnt=0; m_req, m_we, m_addr, m_wdata, m_be, i_ack, d_ack = 0. i_rdata/d_rdata follow m_rdata; stall_f/stall_m stay combinational.
- FSM: IDLE, REQ, WAIT. At most one memory transaction outstanding.
- IDLE: decision when any req is high. D wins if d_req & ~(i_req & ~i_flush & starve_cnt==STARVE_MAX). Otherwise I wins if i_req & ~i_flush. Winner's addr/we/wdata/be are registered into m_* and the FSM goes to REQ. Fetch registers m_we=0 and m_be=all ones.
- starve_cnt: updated on each decision. D grant with i_req high -> +1, saturating at STARVE_MAX. I grant or i_req low -> 0.
- REQ: m_req=1 with stable registered fields until m_gnt. On m_gnt, the FSM goes to WAIT and m_req drops the next cycle. m_req is never withdrawn before m_gnt.
- WAIT: m_req=0. When m_rvalid arrives, pulse owner's ack combinationally in that cycle with rdata=m_rdata, then return to IDLE. Earliest m_rvalid is the cycle after m_gnt.
- Latency, zero-wait memory: req seen in cycle 0, m_req in cycle 1 with gnt, ack in cycle 2. A new decision can occur in cycle 3.
- Flush: i_flush while owner=I in REQ or WAIT sets drop. The memory transaction still completes, i_ack is suppressed, and drop clears on return to IDLE. i_flush in the same cycle as m_rvalid also suppresses i_ack. i_flush in IDLE blocks an I grant that cycle. i_flush never affects a D transaction.
- A requester dropping req after grant (other than fetch via flush) is illegal. The transaction completes and the ack is still pulsed.
- m_rvalid in IDLE or REQ is ignored. m_gnt outside REQ is ignored.
- Reset mid-transaction: immediate return to IDLE, the transaction is abandoned, and no ack is issued.

Test Plan:
- Fetch only, zero-wait memory, i_addr=0x100, m_rdata=0x00500093 -> m_req high in cycle 1, i_ack pulse in cycle 2 with i_rdata=0x00500093, stall_f high in cycles 0-1.
- i_req and d_req in the same IDLE cycle, d_we=1, d_addr=0x2000, d_wdata=0xDEADBEEF, d_be=0xF -> data served first with m_we=1 and matching fields; the fetch is served immediately after d_ack.
- Starvation, STARVE_MAX=4, d_req held with new requests back-to-back and i_req held -> grant order D,D,D,D,I,D...; starve_cnt returns to 0 after the I grant.
- m_gnt delayed 3 cycles and m_rvalid 5 cycles after gnt -> m_req and its fields stay stable for 4 cycles, exactly one d_ack, stall_m high throughout.
- Fetch in WAIT, i_flush pulsed, then m_rvalid -> no i_ack; the FSM returns to IDLE and a pending d_req is granted next.
- reset asserted during WAIT -> all outputs 0 immediately, and a late m_rvalid after deassertion produces no ack.
